// File: rtl/register_transfer_sequencer_pkg.sv
// Register-file control definitions shared by the
// sequencer and the register module.
package cpup_reg_pkg;

    localparam int REG_COUNT = 6;
    localparam int LOAD_BASE = 0;
    localparam int OE_BASE   = 6;
    localparam int CTRL_W    = 12;

    localparam logic [2:0] REG_A  = 3'd0;
    localparam logic [2:0] REG_B  = 3'd1;
    localparam logic [2:0] REG_C  = 3'd2;
    localparam logic [2:0] REG_P  = 3'd3;
    localparam logic [2:0] REG_S  = 3'd4;
    localparam logic [2:0] REG_ST = 3'd5;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_LDI = 2'b01,
        OP_RD  = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [2:0] src;
        logic [2:0] dst;
    } cmd_hdr_t;

    function automatic logic idx_ok(logic [2:0] i);
        return i <= REG_ST;
    endfunction

    // Only the index fields an op actually uses are checked.
    function automatic logic cmd_legal(cmd_hdr_t c);
        logic ok;
        ok = 1'b1;
        unique case (c.op)
            OP_MOV:  ok = idx_ok(c.src) && idx_ok(c.dst);
            OP_LDI:  ok = idx_ok(c.dst);
            OP_RD:   ok = idx_ok(c.src);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [CTRL_W-1:0] load_bit(logic [2:0] i);
        return CTRL_W'(1) << (LOAD_BASE + int'(i));
    endfunction

    function automatic logic [CTRL_W-1:0] oe_bit(logic [2:0] i);
        return CTRL_W'(1) << (OE_BASE + int'(i));
    endfunction

endpackage

// File: rtl/register_transfer_sequencer_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags.
// Push is ignored when full, pop is ignored when empty.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clock_in) begin
        if (do_push) mem[wptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/register_transfer_sequencer.sv
// Master of the register-file control bus: runs queued
// MOV/LDI/RD commands as SETUP, XFER, GAP sequences.
module register_transfer_sequencer
    import cpup_reg_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int DATA_W    = 16
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_src,
    input  logic [2:0]        cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    inout  wire  [DATA_W-1:0] bus,
    output logic [11:0]       Register_Control_Bus,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic              busy
);

    localparam int HW = $bits(cmd_hdr_t);
    localparam int FW = HW + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_GAP,
        S_ERR
    } state_e;

    state_e            state;
    cmd_hdr_t          cur;
    logic              drive_en;
    logic [DATA_W-1:0] drive_data;
    logic [FW-1:0]     head;
    cmd_hdr_t          head_hdr;
    logic [DATA_W-1:0] head_imm;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
    assign head_hdr  = cmd_hdr_t'(head[FW-1:DATA_W]);
    assign head_imm  = head[DATA_W-1:0];
    assign busy      = !fifo_empty || (state != S_IDLE);
    assign bus       = drive_en ? drive_data : {DATA_W{1'bz}};

    cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .push     (cmd_valid),
        .pop      (fifo_pop),
        .wr_data  ({cmd_op, cmd_src, cmd_dst, cmd_imm}),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Transfer sequencer; every output is registered with its state
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state                <= S_IDLE;
            cur                  <= '0;
            Register_Control_Bus <= '0;
            drive_en             <= 1'b0;
            drive_data           <= '0;
            rd_data              <= '0;
            rd_valid             <= 1'b0;
            err                  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur <= head_hdr;
                        if (head_hdr.op == OP_NOP) begin
                            state <= S_IDLE;
                        end else if (!cmd_legal(head_hdr)) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= S_SETUP;
                            if (head_hdr.op == OP_LDI) begin
                                drive_en   <= 1'b1;
                                drive_data <= head_imm;
                            end else begin
                                Register_Control_Bus <= oe_bit(head_hdr.src);
                            end
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_XFER;
                    if (cur.op != OP_RD)
                        Register_Control_Bus <= Register_Control_Bus
                                              | load_bit(cur.dst);
                end
                S_XFER: begin
                    state                <= S_GAP;
                    Register_Control_Bus <= '0;
                    drive_en             <= 1'b0;
                    if (cur.op == OP_RD) begin
                        rd_data  <= bus;
                        rd_valid <= 1'b1;
                    end
                end
                S_GAP:   state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    a_onehot: assert property (@(posedge clock_in) disable iff (reset_in)
        $onehot0(Register_Control_Bus[5:0]) &&
        $onehot0(Register_Control_Bus[11:6]));

    a_no_fight: assert property (@(posedge clock_in)
        !(drive_en && |Register_Control_Bus[11:6]));

    a_quiet: assert property (@(posedge clock_in) disable iff (reset_in)
        (state inside {S_IDLE, S_GAP, S_ERR}) |-> (Register_Control_Bus == '0));

endmodule

// File: tb/tb_register_transfer_sequencer.sv
// Bench for register_transfer_sequencer: register-file model
// on the shared bus plus an event scoreboard.
module tb_register_transfer_sequencer;
    import cpup_reg_pkg::*;

    typedef struct {
        int          kind;
        int          dst;
        logic [15:0] data;
    } ev_t;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b11;
    logic [2:0]  cmd_src = 3'd0;
    logic [2:0]  cmd_dst = 3'd0;
    logic [15:0] cmd_imm = 16'h0;
    wire  [15:0] bus;
    logic [11:0] ctrl;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic        busy;

    logic [15:0] rf [6] = '{default: 16'h0};
    logic [15:0] sb_rf [6] = '{default: 16'h0};
    logic        rf_oe;
    logic [15:0] rf_val;
    ev_t         exp_q [$];
    time         load_t [$];
    int          checks = 0;
    int          errors = 0;

    register_transfer_sequencer #(.CMD_DEPTH(4), .DATA_W(16)) dut (
        .clock_in             (clock_in),
        .reset_in             (reset_in),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_src              (cmd_src),
        .cmd_dst              (cmd_dst),
        .cmd_imm              (cmd_imm),
        .bus                  (bus),
        .Register_Control_Bus (ctrl),
        .rd_data              (rd_data),
        .rd_valid             (rd_valid),
        .err                  (err),
        .busy                 (busy)
    );

    always #5 clock_in = ~clock_in;

    // Register file model: drives the bus on an output enable
    always_comb begin
        rf_oe  = 1'b0;
        rf_val = 16'h0;
        for (int i = 0; i < 6; i++) begin
            if (ctrl[6+i]) begin
                rf_oe  = 1'b1;
                rf_val = rf[i];
            end
        end
    end
    assign bus = rf_oe ? rf_val : 16'hzzzz;

    // Capture loads (falling edge inside XFER) and score events
    always @(negedge clock_in) begin
        if (!reset_in && (ctrl[5:0] != 6'h0 || rd_valid || err)) begin
            ev_t g;
            ev_t e;
            g = '{0, 0, 16'h0};
            if (err) begin
                g.kind = 2;
            end else if (rd_valid) begin
                g.kind = 1;
                g.data = rd_data;
            end else begin
                for (int i = 0; i < 6; i++)
                    if (ctrl[i]) g.dst = i;
                g.data = bus;
                rf[g.dst] = bus;
                load_t.push_back($time);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event kind=%0d dst=%0d data=%h required=none",
                         g.kind, g.dst, g.data);
            end else begin
                e = exp_q.pop_front();
                if (g.kind !== e.kind ||
                    (e.kind == 0 && g.dst !== e.dst) ||
                    (e.kind != 2 && g.data !== e.data)) begin
                    errors++;
                    $display("FAIL event kind=%0d dst=%0d data=%h required kind=%0d dst=%0d data=%h",
                             g.kind, g.dst, g.data, e.kind, e.dst, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [1:0] op, input logic [2:0] src,
                        input logic [2:0] dst, input logic [15:0] imm);
        ev_t e;
        int  n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_imm   = imm;
        if (op != OP_NOP) begin
            if ((op == OP_MOV && (src > 5 || dst > 5)) ||
                (op == OP_LDI && dst > 5) || (op == OP_RD && src > 5)) begin
                e = '{2, 0, 16'h0};
            end else if (op == OP_LDI) begin
                e = '{0, int'(dst), imm};
                sb_rf[dst] = imm;
            end else if (op == OP_MOV) begin
                e = '{0, int'(dst), sb_rf[src]};
                sb_rf[dst] = sb_rf[src];
            end else begin
                e = '{1, 0, sb_rf[src]};
            end
            exp_q.push_back(e);
        end
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clock_in);
            n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout cmd_ready=%b required=1", cmd_ready);
        end
        @(posedge clock_in);
        @(negedge clock_in);
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (2) @(negedge clock_in);
        reset_in = 1'b0;
        checks++; if (ctrl !== 12'h0) begin errors++; $display("FAIL rst_ctrl got=%h required=000", ctrl); end
        checks++; if (!(bus === 16'hzzzz || bus === 16'h0)) begin errors++; $display("FAIL rst_bus got=%h required=released", bus); end
        checks++; if (rd_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_pulses rd_valid=%b err=%b required=0", rd_valid, err); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data got=%h required=0000", rd_data); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_flags busy=%b ready=%b required 0/1", busy, cmd_ready); end
    endtask

    task automatic test_ldi();
        send(OP_LDI, 3'd0, REG_A, 16'h1234);
        cmd_valid = 1'b0;
        @(negedge clock_in);
        checks++; if (ctrl !== 12'h000) begin errors++; $display("FAIL ldi_setup_ctrl got=%h required=000", ctrl); end
        checks++; if (bus !== 16'h1234) begin errors++; $display("FAIL ldi_setup_bus got=%h required=1234", bus); end
        @(negedge clock_in);
        checks++; if (ctrl !== 12'h001) begin errors++; $display("FAIL ldi_xfer_ctrl got=%h required=001", ctrl); end
        checks++; if (bus !== 16'h1234) begin errors++; $display("FAIL ldi_xfer_bus got=%h required=1234", bus); end
        @(negedge clock_in);
        checks++; if (ctrl !== 12'h000) begin errors++; $display("FAIL ldi_gap_ctrl got=%h required=000", ctrl); end
        checks++; if (!(bus === 16'hzzzz || bus === 16'h0)) begin errors++; $display("FAIL ldi_gap_bus got=%h required=released", bus); end
        checks++; if (rf[0] !== 16'h1234) begin errors++; $display("FAIL ldi_reg_a got=%h required=1234", rf[0]); end
        @(negedge clock_in);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ldi_idle_busy got=%b required=0", busy); end
    endtask

    task automatic test_mov();
        send(OP_MOV, REG_A, REG_C, 16'h0);
        cmd_valid = 1'b0;
        @(negedge clock_in);
        checks++; if (ctrl !== 12'h040) begin errors++; $display("FAIL mov_setup_ctrl got=%h required=040", ctrl); end
        @(negedge clock_in);
        checks++; if (ctrl !== 12'h044) begin errors++; $display("FAIL mov_xfer_ctrl got=%h required=044", ctrl); end
        @(negedge clock_in);
        checks++; if (rf[2] !== 16'h1234 || rf[0] !== 16'h1234) begin errors++; $display("FAIL mov_regs c=%h a=%h required=1234/1234", rf[2], rf[0]); end
        @(negedge clock_in);
    endtask

    task automatic test_rd();
        send(OP_RD, REG_C, 3'd0, 16'h0);
        cmd_valid = 1'b0;
        @(negedge clock_in);
        checks++; if (ctrl !== 12'h100) begin errors++; $display("FAIL rd_setup_ctrl got=%h required=100", ctrl); end
        @(negedge clock_in);
        checks++; if (ctrl !== 12'h100 || rd_valid !== 1'b0) begin errors++; $display("FAIL rd_xfer ctrl=%h rd_valid=%b required=100/0", ctrl, rd_valid); end
        @(negedge clock_in);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin errors++; $display("FAIL rd_gap rd_valid=%b rd_data=%h required=1/1234", rd_valid, rd_data); end
        @(negedge clock_in);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_width got=%b required=0", rd_valid); end
    endtask

    task automatic test_err();
        logic [15:0] b0;
        b0 = rf[1];
        send(OP_MOV, 3'd7, REG_B, 16'h0);
        cmd_valid = 1'b0;
        @(negedge clock_in);
        checks++; if (err !== 1'b1 || ctrl !== 12'h0) begin errors++; $display("FAIL err_pulse err=%b ctrl=%h required=1/000", err, ctrl); end
        @(negedge clock_in);
        checks++; if (err !== 1'b0 || ctrl !== 12'h0) begin errors++; $display("FAIL err_after err=%b ctrl=%h required=0/000", err, ctrl); end
        checks++; if (rf[1] !== b0) begin errors++; $display("FAIL err_reg_b got=%h required=%h", rf[1], b0); end
        send(OP_LDI, 3'd0, REG_B, 16'h5A5A);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clock_in);
        checks++; if (rf[1] !== 16'h5A5A) begin errors++; $display("FAIL err_next_cmd got=%h required=5a5a", rf[1]); end
    endtask

    task automatic test_back_to_back();
        load_t.delete();
        send(OP_RD, REG_B, 3'd0, 16'h0);
        for (int k = 0; k < 5; k++) begin
            send(OP_LDI, 3'd0, 3'(k), 16'(16'h1100 * (k + 1)));
            if (k == 3) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b required=0", cmd_ready); end
            end
        end
        cmd_valid = 1'b0;
        repeat (24) @(negedge clock_in);
        checks++; if (load_t.size() != 5) begin errors++; $display("FAIL b2b_load_count got=%0d required=5", load_t.size()); end
        for (int k = 1; k < 5 && k < load_t.size(); k++) begin
            checks++;
            if (load_t[k] - load_t[k-1] != 40) begin
                errors++;
                $display("FAIL b2b_spacing idx=%0d got=%0t required=40", k, load_t[k] - load_t[k-1]);
            end
        end
        checks++; if (rf[4] !== 16'h5500 || busy !== 1'b0) begin errors++; $display("FAIL b2b_final reg_s=%h busy=%b required=5500/0", rf[4], busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        send(OP_MOV, REG_A, REG_B, 16'h0);
        send(OP_LDI, 3'd0, REG_ST, 16'hBEEF);
        cmd_valid = 1'b0;
        n = 0;
        while (ctrl[5:0] == 6'h0 && n < 10) begin
            @(negedge clock_in);
            n++;
        end
        checks++; if (ctrl !== 12'h042) begin errors++; $display("FAIL rmid_xfer_ctrl got=%h required=042", ctrl); end
        #1 reset_in = 1'b1;
        @(negedge clock_in);
        reset_in = 1'b0;
        checks++; if (ctrl !== 12'h0) begin errors++; $display("FAIL rmid_ctrl got=%h required=000", ctrl); end
        checks++; if (!(bus === 16'hzzzz || bus === 16'h0)) begin errors++; $display("FAIL rmid_bus got=%h required=released", bus); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b required=0", busy); end
        checks++; if (rd_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rmid_pulses rd_valid=%b err=%b required=0", rd_valid, err); end
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL rmid_pending got=%0d required=1", exp_q.size()); end
        exp_q.delete();
        sb_rf = rf;
        repeat (8) @(negedge clock_in);
        checks++; if (rf[5] !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_abandon reg_st=%h busy=%b required=0000/0", rf[5], busy); end
    endtask

    initial begin
        @(negedge clock_in);
        test_reset();
        test_ldi();
        test_mov();
        test_rd();
        test_err();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_transfer_sequencer.md
Name: register_transfer_sequencer

Overview:
- Master end of the register-file control interface: turns queued transfer commands into the one-hot 12-bit Register_Control_Bus.
- Control bus layout: bits [5:0] are load enables; bits [11:6] are output enables; register order is A,B,C,P,S,ST.
- Owns the shared 16-bit tri-state bus for immediate loads and samples it for register reads.
- Sits between the instruction decode/microcode logic and the register module.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of two, ≥2)
- DATA_W, 16, bus width

Ports:
- clock_in  input  1  system clock
- reset_in  input  1  synchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept the command
- cmd_op  input  2  00 MOV, 01 LDI, 10 RD, 11 NOP
- cmd_src  input  3  source register index 0..5 (A,B,C,P,S,ST)
- cmd_dst  input  3  destination register index 0..5
- cmd_imm  input  DATA_W  immediate value for LDI
- bus  inout  DATA_W  shared register bus
- Register_Control_Bus  output  12  one-hot load/output enables
- rd_data  output  DATA_W  value captured by RD
- rd_valid  output  1  one-cycle pulse, rd_data valid
- err  output  1  one-cycle pulse, illegal index dropped
- busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (synchronous, active-high, one edge):
  - Register_Control_Bus=0, bus released (Z), rd_data=0, rd_valid=0, err=0.
  - FIFO emptied; FSM returns to IDLE.
  - Applies from any state; an in-flight command is abandoned with no load asserted afterwards.
- FIFO:
  - cmd_ready = !full.
  - Push on cmd_valid && cmd_ready.
  - No pass-through when full: ready is already low, so a same-cycle pop does not admit a push.
  - Pop occurs on the IDLE→SETUP (or IDLE→ERR) transition.
- FSM states, all outputs registered:
  - IDLE: control=0, bus Z. If FIFO non-empty, pop and check indices.
    - NOP: consumed, stays IDLE.
    - Index >5 in any field the op uses (MOV: src,dst; LDI: dst; RD: src): go to ERR.
    - Otherwise go to SETUP.
  - SETUP (1 cycle):
    - MOV/RD: assert oe bit 6+src only.
    - LDI: drive bus=imm, all oe bits 0.
  - XFER (1 cycle): hold SETUP drive.
    - MOV/LDI: also assert load bit dst; the register file captures on the falling edge inside XFER.
    - RD: sample bus at the closing rising edge into rd_data; rd_valid=1 in the following cycle (GAP).
  - GAP (1 cycle): control=0, bus Z (turnaround). Then IDLE.
  - ERR (1 cycle): err=1, control=0. Then IDLE.
- Timing: legal command from FIFO head takes 4 cycles, IDLE→SETUP→XFER→GAP→IDLE; no back-to-back overlap.
- Invariants, checked by assertion:
  - At most one load bit and at most one oe bit high.
  - Sequencer bus drive and any oe bit are never high together.
  - Control bus is 0 in IDLE, GAP, ERR and reset.
- MOV with src==dst is legal and runs the normal sequence.
- busy is combinational from FIFO count and state.

Decomposition:
- Shared package cpup_reg_pkg holds:
  - Register indices REG_A=0 … REG_ST=5.
  - Op codes OP_MOV/OP_LDI/OP_RD/OP_NOP.
  - Control field bases LOAD_BASE=0, OE_BASE=6; REG_COUNT=6.
- The register module and this block both use the package.
- One sub-module, cmd_fifo: synchronous, parameterised width/depth, full/empty flags, synchronous active-high reset. The FSM stays in the top.

Test Plan:
- Reset, then LDI dst=A imm=0x1234 → SETUP: control=0x000, bus=0x1234; XFER: control=0x001, bus=0x1234; GAP: control=0, bus Z; register model A=0x1234.
- MOV src=A dst=C after LDI → SETUP control=0x040; XFER control=0x044; model C=0x1234, A unchanged.
- RD src=C → control 0x100 in SETUP and XFER; rd_valid pulses once, rd_data=0x1234 in the same cycle.
- MOV src=7 dst=B → err pulses one cycle, control stays 0, B unchanged, next command runs normally.
- Five back-to-back LDIs with cmd_valid held high (CMD_DEPTH=4) → cmd_ready low after the 4th accept, 5th accepted after first pop, all five execute in order, 4 cycles each.
- reset_in asserted during XFER of a MOV → next cycle control=0, bus Z, FIFO empty, busy=0, no rd_valid/err.
